fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
- Decoupling FIFO between the instruction-cache fetch register and the 4-wide decode stage.
- Each entry holds one fetch packet: packet PC, four 32-bit instructions and a 4-bit instruction-valid mask.
- Absorbs decode/rename backpressure so the fetch pipeline keeps running.
- Discards all contents on a front-end flush (branch kill or redirect).

Parameters:
- DEPTH, 8, number of packet entries; power of two, minimum 2.
- ADDR_WIDTH, 32, PC width.
- FETCH_WIDTH, 4, instructions per packet.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_flush  input  1  discard all entries and any in-flight push this cycle.
- i_valid  input  1  fetch packet present on i_pc/i_inst4x/i_imask.
- i_pc  input  ADDR_WIDTH  PC of slot 0 of the incoming packet.
- i_inst4x  input  32*FETCH_WIDTH  instructions; slot k occupies bits [32k+31:32k].
- i_imask  input  FETCH_WIDTH  per-slot valid bits.
- o_ready  output  1  buffer can accept a packet this cycle.
- o_valid  output  1  head packet available to decode.
- o_pc  output  ADDR_WIDTH  head packet PC.
- o_inst4x  output  32*FETCH_WIDTH  head packet instructions.
- o_imask  output  FETCH_WIDTH  head packet mask.
- i_ready  input  1  decode consumes the head packet this cycle.
- o_count  output  clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Storage: circular array of DEPTH entries. Write and read pointers are clog2(DEPTH)+1 bits wide; the extra MSB is the wrap bit.
  - full = (pointer LSBs equal) and (MSBs differ).
  - empty = pointers equal.
- Reset (i_rst_n low, asynchronous): pointers = 0; o_count = 0; o_valid = 0; o_ready = 1. o_pc, o_inst4x and o_imask read as 0. Entry contents need not be reset.
- push = i_valid & o_ready & ~i_flush & (|i_imask). A packet with i_imask == 0 is dropped silently and is never stored.
- pop = o_valid & i_ready & ~i_flush.
- o_ready = ~full. It does not depend on i_ready, so a push while full is refused even if a pop happens in the same cycle.
- Outputs are first-word-fall-through: o_pc, o_inst4x and o_imask show the entry at the read pointer. o_valid = ~empty.
- Push-to-visible latency is 1 cycle: a packet pushed at edge N appears at the outputs after edge N.
- Simultaneous push and pop (not full, not empty): both pointers advance and o_count is unchanged.
- Flush: on the edge where i_flush = 1, both pointers are set to the write pointer and o_count = 0. Flush overrides push and pop in that cycle.
- Pointers wrap modulo 2*DEPTH. Ordering is strictly FIFO across the wrap.
- o_count = wptr - rptr (modular), ranging 0..DEPTH. It is registered alongside the pointers.
- When o_valid = 0, outputs are driven to 0 (not stale entry data).

Optional Feature:
- Macro: FETCH_BUFFER_BYPASS_EN.
- Defined: when the buffer is empty and i_valid & |i_imask & ~i_flush, the input packet is forwarded combinationally to the outputs and o_valid = 1 in the same cycle.
  - If i_ready is also 1, the packet is consumed and not written; pointers are unchanged.
  - Otherwise it is written normally.
  - Empty-buffer latency is 0 cycles.
- Not defined: no combinational input-to-output path; latency is always 1 cycle.

Decomposition:
- Package core_pkg holds:
  - FETCH_WIDTH = 4 and INST_WIDTH = 32.
  - Typedef fetch_pkt_t {pc, inst4x, imask}, reused by the decode and rename stages.
- One sub-module: fifo_ptr. It is a wrap-bit pointer counter with increment, load and reset, and is instantiated for the read and write pointers. Full, empty and count are derived in fetch_buffer.

Test Plan:
- Reset then single push: i_pc = 0x100, i_imask = 4'b1111, i_ready = 0 -> o_valid = 1 and o_pc = 0x100 one cycle later; o_count = 1.
- Fill to DEPTH = 8 with i_ready = 0 -> o_ready = 0 and o_count = 8. A 9th packet (pc 0x200) is not stored; draining yields exactly 8 packets in PC order.
- Continuous push and pop for 20 cycles with wrap-around (PCs 0x0, 0x10, ...) -> output PC sequence matches input; o_count is constant at its steady value.
- Push a packet with i_imask = 0 -> o_count unchanged, o_valid stays 0.
- With 5 entries, assert i_flush together with i_valid = 1 and i_ready = 1 -> next cycle o_count = 0 and o_valid = 0; the flushed-cycle packet does not appear.
- Assert i_rst_n low mid-stream with 3 entries -> outputs go to 0 asynchronously before the next clock edge, o_ready = 1. With FETCH_BUFFER_BYPASS_EN, a push into the empty buffer with i_ready = 1 gives o_valid = 1 the same cycle and o_count stays 0.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared front-end types.
//   FETCH_WIDTH  instructions per fetch packet
//   INST_WIDTH   bits per instruction
//   PC_WIDTH     packet PC width
//   fetch_pkt_t  {pc, inst4x, imask}; also used by the decode and rename stages
package core_pkg;

    localparam int FETCH_WIDTH = 4;
    localparam int INST_WIDTH  = 32;
    localparam int PC_WIDTH    = 32;

    typedef struct packed {
        logic [PC_WIDTH-1:0]               pc;
        logic [INST_WIDTH*FETCH_WIDTH-1:0] inst4x;
        logic [FETCH_WIDTH-1:0]            imask;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// fetch_buffer_if: fetch-side push port, decode-side pop port and flush.
//   slave  modport: the buffer (takes i_*, drives o_*)
//   master modport: fetch/decode environment (drives i_*, takes o_*)
interface fetch_buffer_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int FETCH_WIDTH = 4,
    parameter int CNT_WIDTH   = 4
);
    logic                      i_flush;
    logic                      i_valid;
    logic [ADDR_WIDTH-1:0]     i_pc;
    logic [32*FETCH_WIDTH-1:0] i_inst4x;
    logic [FETCH_WIDTH-1:0]    i_imask;
    logic                      o_ready;
    logic                      o_valid;
    logic [ADDR_WIDTH-1:0]     o_pc;
    logic [32*FETCH_WIDTH-1:0] o_inst4x;
    logic [FETCH_WIDTH-1:0]    o_imask;
    logic                      i_ready;
    logic [CNT_WIDTH-1:0]      o_count;

    modport slave (
        input  i_flush, i_valid, i_pc, i_inst4x, i_imask, i_ready,
        output o_ready, o_valid, o_pc, o_inst4x, o_imask, o_count
    );

    modport master (
        output i_flush, i_valid, i_pc, i_inst4x, i_imask, i_ready,
        input  o_ready, o_valid, o_pc, o_inst4x, o_imask, o_count
    );
endinterface

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrap-bit FIFO pointer (index bits plus one wrap MSB).
//   i_clk, i_rst_n  clock, async active-low reset (pointer -> 0)
//   i_load, i_val   load i_val (takes priority over increment)
//   i_inc           advance by one, wrapping modulo 2**W
//   o_ptr           current pointer
module fifo_ptr #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_ptr
);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ptr <= '0;
        end else if (i_load) begin
            o_ptr <= i_val;
        end else if (i_inc) begin
            o_ptr <= o_ptr + W'(1);
        end
    end
endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: packet FIFO between the I-cache fetch register and 4-wide decode.
//   i_clk, i_rst_n  clock, async active-low reset
//   bus (slave)     push: i_valid/i_pc/i_inst4x/i_imask, o_ready
//                   pop:  o_valid/o_pc/o_inst4x/o_imask, i_ready
//                   i_flush discards everything, o_count = occupancy
// Outputs are first-word-fall-through and read as zero while empty.
// Optional macro FETCH_BUFFER_BYPASS_EN: an incoming packet is forwarded
// combinationally when the buffer is empty (zero-cycle latency).
module fetch_buffer #(
    parameter int DEPTH       = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int FETCH_WIDTH = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    fetch_buffer_if.slave  bus
);
    import core_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    fetch_pkt_t    mem [DEPTH];
    fetch_pkt_t    head;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] count;
    logic          full;
    logic          empty;
    logic          has_pkt;
    logic          bypass;
    logic          push;
    logic          pop;

    assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign empty   = (wptr == rptr);
    assign has_pkt = bus.i_valid && (|bus.i_imask) && !bus.i_flush;

`ifdef FETCH_BUFFER_BYPASS_EN
    assign bypass = empty && has_pkt;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed packet that decode takes immediately never enters storage.
    assign push = has_pkt && !full && !(bypass && bus.i_ready);
    assign pop  = !empty && bus.i_ready && !bus.i_flush;

    fifo_ptr #(.W(PW)) u_wptr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (push),
        .i_load  (1'b0),
        .i_val   (wptr),
        .o_ptr   (wptr)
    );

    // Flush collapses the queue by pulling the read pointer up to the write pointer.
    fifo_ptr #(.W(PW)) u_rptr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (pop),
        .i_load  (bus.i_flush),
        .i_val   (wptr),
        .o_ptr   (rptr)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (bus.i_flush) begin
            count <= '0;
        end else begin
            count <= count + PW'(push) - PW'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= '{pc: bus.i_pc, inst4x: bus.i_inst4x, imask: bus.i_imask};
        end
    end

    always_comb begin
        head = '0;
        if (bypass) begin
            head = '{pc: bus.i_pc, inst4x: bus.i_inst4x, imask: bus.i_imask};
        end else if (!empty) begin
            head = mem[rptr[AW-1:0]];
        end
    end

    assign bus.o_ready  = !full;
    assign bus.o_valid  = !empty || bypass;
    assign bus.o_pc     = head.pc;
    assign bus.o_inst4x = head.inst4x;
    assign bus.o_imask  = head.imask;
    assign bus.o_count  = count;
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed bench for fetch_buffer (DEPTH = 8).
module tb_fetch_buffer;
    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 i_clk = ~i_clk;

    fetch_buffer_if #(.ADDR_WIDTH(32), .FETCH_WIDTH(4), .CNT_WIDTH(4)) bus ();

    fetch_buffer #(.DEPTH(8), .ADDR_WIDTH(32), .FETCH_WIDTH(4)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [3:0] m, input logic rdy);
        bus.i_valid  = v;
        bus.i_pc     = pc;
        bus.i_inst4x = {pc + 32'd3, pc + 32'd2, pc + 32'd1, pc};
        bus.i_imask  = m;
        bus.i_ready  = rdy;
    endtask

    initial begin
        bus.i_flush = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        #12;
        // Reset state
        chk("rst_count", 128'(bus.o_count), 128'd0);
        chk("rst_valid", 128'(bus.o_valid), 128'd0);
        chk("rst_ready", 128'(bus.o_ready), 128'd1);
        chk("rst_pc", 128'(bus.o_pc), 128'd0);
        i_rst_n = 1'b1;
        step();

        // Single push
        drive(1'b1, 32'h100, 4'hF, 1'b0);
        step();
        bus.i_valid = 1'b0;
        chk("single_valid", 128'(bus.o_valid), 128'd1);
        chk("single_pc", 128'(bus.o_pc), 128'h100);
        chk("single_inst", 128'(bus.o_inst4x), {32'h103, 32'h102, 32'h101, 32'h100});
        chk("single_mask", 128'(bus.o_imask), 128'hF);
        chk("single_count", 128'(bus.o_count), 128'd1);

        // Fill to 8, then a refused 9th
        for (int k = 1; k < 8; k++) begin
            drive(1'b1, 32'h100 + 32'(k) * 32'h10, 4'hF, 1'b0);
            step();
        end
        chk("full_count", 128'(bus.o_count), 128'd8);
        chk("full_ready", 128'(bus.o_ready), 128'd0);
        drive(1'b1, 32'h200, 4'hF, 1'b0);
        step();
        chk("ninth_count", 128'(bus.o_count), 128'd8);
        drive(1'b0, 32'h0, 4'h0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain_pc%0d", k), 128'(bus.o_pc), 128'(32'h100 + 32'(k) * 32'h10));
            step();
        end
        chk("drain_valid", 128'(bus.o_valid), 128'd0);
        chk("drain_count", 128'(bus.o_count), 128'd0);
        chk("drain_pc_zero", 128'(bus.o_pc), 128'd0);

        // Continuous push/pop across the pointer wrap
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 32'(k) * 32'h10, 4'hF, 1'b1);
            step();
`ifdef FETCH_BUFFER_BYPASS_EN
            chk($sformatf("stream_count%0d", k), 128'(bus.o_count), 128'd0);
`else
            chk($sformatf("stream_count%0d", k), 128'(bus.o_count), 128'd1);
            chk($sformatf("stream_pc%0d", k), 128'(bus.o_pc), 128'(32'(k) * 32'h10));
`endif
        end
        drive(1'b0, 32'h0, 4'h0, 1'b1);
        step();
        chk("stream_end_count", 128'(bus.o_count), 128'd0);

        // Empty mask is dropped
        drive(1'b1, 32'h400, 4'h0, 1'b0);
        step();
        chk("nomask_count", 128'(bus.o_count), 128'd0);
        chk("nomask_valid", 128'(bus.o_valid), 128'd0);

        // Flush with 5 entries, concurrent push and pop
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h300 + 32'(k) * 32'h10, 4'h3, 1'b0);
            step();
        end
        chk("pre_flush_count", 128'(bus.o_count), 128'd5);
        drive(1'b1, 32'h999, 4'hF, 1'b1);
        bus.i_flush = 1'b1;
        step();
        bus.i_flush = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        chk("flush_count", 128'(bus.o_count), 128'd0);
        chk("flush_valid", 128'(bus.o_valid), 128'd0);
        chk("flush_pc", 128'(bus.o_pc), 128'd0);
        step();
        chk("flush_after_valid", 128'(bus.o_valid), 128'd0);

        // Asynchronous reset mid-stream with 3 entries
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h500 + 32'(k) * 32'h10, 4'hF, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        chk("pre_rst_count", 128'(bus.o_count), 128'd3);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_valid", 128'(bus.o_valid), 128'd0);
        chk("arst_pc", 128'(bus.o_pc), 128'd0);
        chk("arst_ready", 128'(bus.o_ready), 128'd1);
        chk("arst_count", 128'(bus.o_count), 128'd0);
        step();
        i_rst_n = 1'b1;
        step();

        // Push into empty buffer with decode ready
        drive(1'b1, 32'h600, 4'hF, 1'b1);
        #1;
`ifdef FETCH_BUFFER_BYPASS_EN
        chk("byp_valid", 128'(bus.o_valid), 128'd1);
        chk("byp_pc", 128'(bus.o_pc), 128'h600);
        step();
        bus.i_valid = 1'b0;
        chk("byp_count", 128'(bus.o_count), 128'd0);
`else
        chk("nobyp_valid", 128'(bus.o_valid), 128'd0);
        step();
        bus.i_valid = 1'b0;
        chk("nobyp_count", 128'(bus.o_count), 128'd1);
        chk("nobyp_pc", 128'(bus.o_pc), 128'h600);
`endif
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
